// File: rtl/spio_link_pkg.sv
// Shared definitions for the spio link arbitration blocks: default packet
// width, index-width helper and packet slicing within a concatenated bus.
package spio_link_pkg;

  localparam int PKT_BITS_DEF = 72;

  // Width of a port index; never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // LSB of packet 'port' within a bus of concatenated packets.
  function automatic int pkt_lsb(input int port, input int pkt_bits);
    return port * pkt_bits;
  endfunction

endpackage

// File: rtl/spio_rr_select.sv
// Round-robin selector: finds the first requester after last_i, with wrap,
// using a rotate / priority-encode / un-rotate structure.
module spio_rr_select
  import spio_link_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_BITS  = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [SEL_BITS-1:0]  last_i,
  output logic [SEL_BITS-1:0]  sel_o,
  output logic                 any_o
);

  int                   start_s;
  int                   off_s;
  int                   sel_idx_s;
  logic [NUM_PORTS-1:0] rot_s;

  // Rotate requests so the port after last_i sits at bit 0, pick the lowest, rotate back.
  always_comb begin
    start_s = int'(last_i) + 1;
    if (start_s >= NUM_PORTS) begin
      start_s = start_s - NUM_PORTS;
    end else begin
      start_s = start_s;
    end

    rot_s = NUM_PORTS'({req_i, req_i} >> start_s);

    off_s = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = k;
      end else begin
        off_s = off_s;
      end
    end

    sel_idx_s = start_s + off_s;
    if (sel_idx_s >= NUM_PORTS) begin
      sel_idx_s = sel_idx_s - NUM_PORTS;
    end else begin
      sel_idx_s = sel_idx_s;
    end

    sel_o = SEL_BITS'(sel_idx_s);
    any_o = |req_i;
  end

endmodule

// File: rtl/spio_link_rr_arbiter.sv
// Round-robin arbiter sharing one rdy/vld packet link among NUM_PORTS sources,
// with a single registered output stage sustaining one packet per cycle.
module spio_link_rr_arbiter
  import spio_link_pkg::*;
#(
  parameter int PKT_BITS  = PKT_BITS_DEF,
  parameter int NUM_PORTS = 4,
  parameter int SEL_BITS  = clog2_min1(NUM_PORTS)
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [NUM_PORTS*PKT_BITS-1:0] DATA_IN,
  input  logic [NUM_PORTS-1:0]          VLD_IN,
  output logic [NUM_PORTS-1:0]          RDY_OUT,
  output logic [PKT_BITS-1:0]           DATA_OUT,
  output logic                          VLD_OUT,
  input  logic                          RDY_IN,
  output logic [SEL_BITS-1:0]           GRANT_OUT
);

  logic [SEL_BITS-1:0] sel_s;
  logic                any_s;
  logic                out_free_s;
  logic                accept_s;
  logic [PKT_BITS-1:0] pick_s;

  logic [PKT_BITS-1:0] data_q,  data_d;
  logic                vld_q,   vld_d;
  logic [SEL_BITS-1:0] grant_q, grant_d;
  logic [SEL_BITS-1:0] last_q,  last_d;

  spio_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_BITS  (SEL_BITS)
  ) u_select (
    .req_i  (VLD_IN),
    .last_i (last_q),
    .sel_o  (sel_s),
    .any_o  (any_s)
  );

  // Arbitration is only committed when the output register can take a packet.
  always_comb begin
    out_free_s = !vld_q || RDY_IN;
    accept_s   = any_s && out_free_s;

    pick_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_s == SEL_BITS'(i)) begin
        pick_s = DATA_IN[pkt_lsb(i, PKT_BITS) +: PKT_BITS];
      end else begin
        pick_s = pick_s;
      end
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      RDY_OUT[i] = !RESET_IN && accept_s && (sel_s == SEL_BITS'(i));
    end

    data_d  = data_q;
    vld_d   = vld_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (accept_s) begin
      data_d  = pick_s;
      vld_d   = 1'b1;
      grant_d = sel_s;
      last_d  = sel_s;
    end else if (vld_q && RDY_IN) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      data_q  <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      last_q  <= SEL_BITS'(NUM_PORTS - 1);
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign VLD_OUT   = vld_q;
  assign GRANT_OUT = grant_q;

endmodule

// File: tb/tb_spio_link_rr_arbiter.sv
// Directed bench for spio_link_rr_arbiter (4 ports, 72-bit packets).
module tb_spio_link_rr_arbiter;

  localparam int PB = 72;
  localparam int NP = 4;

  logic             clk;
  logic             rst;
  logic [NP*PB-1:0] data_in;
  logic [NP-1:0]    vld_in;
  logic [NP-1:0]    rdy_out;
  logic [PB-1:0]    data_out;
  logic             vld_out;
  logic             rdy_in;
  logic [1:0]       grant_out;

  int checks;
  int errors;

  spio_link_rr_arbiter #(
    .PKT_BITS  (PB),
    .NUM_PORTS (NP)
  ) dut (
    .CLK_IN    (clk),
    .RESET_IN  (rst),
    .DATA_IN   (data_in),
    .VLD_IN    (vld_in),
    .RDY_OUT   (rdy_out),
    .DATA_OUT  (data_out),
    .VLD_OUT   (vld_out),
    .RDY_IN    (rdy_in),
    .GRANT_OUT (grant_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pkt(input int port, input logic [PB-1:0] val);
    data_in[port*PB +: PB] = val;
  endtask

  // Called at a falling edge: drive inputs, check the combinational ready,
  // then advance to the next falling edge (one rising edge in between).
  task automatic cyc(input string tag, input logic [NP-1:0] vld, input logic rin,
                     input logic [NP-1:0] exp_rdy);
    vld_in = vld;
    rdy_in = rin;
    #1;
    chk({tag, "_rdy"}, PB'(rdy_out), PB'(exp_rdy));
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic exp_vld, input logic [1:0] exp_gnt,
                         input logic [PB-1:0] exp_data);
    chk({tag, "_vld"}, PB'(vld_out), PB'(exp_vld));
    chk({tag, "_gnt"}, PB'(grant_out), PB'(exp_gnt));
    chk({tag, "_data"}, data_out, exp_data);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    data_in = '0;
    vld_in  = 4'b1111;
    rdy_in  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_vld", PB'(vld_out), PB'(1'b0));
    chk("reset_gnt", PB'(grant_out), PB'(2'd0));
    chk("reset_rdy", PB'(rdy_out), PB'(4'b0000));

    // Single packet from port 0.
    @(negedge clk);
    rst = 1'b0;
    set_pkt(0, 72'hA5);
    cyc("t1_acc", 4'b0001, 1'b1, 4'b0001);
    chk_out("t1_out", 1'b1, 2'd0, 72'hA5);
    cyc("t1_idle", 4'b0000, 1'b1, 4'b0000);
    chk("t1_drain_vld", PB'(vld_out), PB'(1'b0));

    // Reset, then all ports valid: strict rotation 0,1,2,3,0,1,2,3.
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < NP; p++) set_pkt(p, 72'h100 + 72'(p));
    for (int k = 0; k < 8; k++) begin
      cyc("t2_all", 4'b1111, 1'b1, 4'(1 << (k % NP)));
      chk_out("t2_out", 1'b1, 2'(k % NP), 72'h100 + 72'(k % NP));
    end
    cyc("t2_idle", 4'b0000, 1'b1, 4'b0000);
    chk("t2_drain_vld", PB'(vld_out), PB'(1'b0));

    // Ports 1 and 3 alternate once last_i=1.
    cyc("t3_p1", 4'b0010, 1'b1, 4'b0010);
    chk_out("t3_a", 1'b1, 2'd1, 72'h101);
    cyc("t3_b", 4'b1010, 1'b1, 4'b1000);
    chk_out("t3_b", 1'b1, 2'd3, 72'h103);
    cyc("t3_c", 4'b1010, 1'b1, 4'b0010);
    chk_out("t3_c", 1'b1, 2'd1, 72'h101);
    cyc("t3_d", 4'b1010, 1'b1, 4'b1000);
    chk_out("t3_d", 1'b1, 2'd3, 72'h103);

    // Stall with 72'h11 held; release consumes and accepts in one cycle.
    set_pkt(0, 72'h11);
    set_pkt(1, 72'h22);
    set_pkt(2, 72'h33);
    set_pkt(3, 72'h44);
    cyc("t4_load", 4'b0001, 1'b1, 4'b0001);
    chk_out("t4_load", 1'b1, 2'd0, 72'h11);
    for (int k = 0; k < 5; k++) begin
      cyc("t4_stall", 4'b1111, 1'b0, 4'b0000);
      chk_out("t4_stall", 1'b1, 2'd0, 72'h11);
    end
    cyc("t4_rel", 4'b1111, 1'b1, 4'b0010);
    chk_out("t4_rel", 1'b1, 2'd1, 72'h22);

    // Only port 2 valid: six back-to-back grants with fresh data each.
    for (int k = 0; k < 6; k++) begin
      set_pkt(2, 72'h200 + 72'(k));
      cyc("t5_p2", 4'b0100, 1'b1, 4'b0100);
      chk_out("t5_p2", 1'b1, 2'd2, 72'h200 + 72'(k));
    end

    // Reset while stalled discards the packet; then port 0 wins first.
    set_pkt(2, 72'h33);
    cyc("t6_stall", 4'b1111, 1'b0, 4'b0000);
    chk_out("t6_stall", 1'b1, 2'd2, 72'h205);
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", PB'(vld_out), PB'(1'b0));
    chk("t6_rst_rdy", PB'(rdy_out), PB'(4'b0000));
    @(negedge clk);
    rst = 1'b0;
    cyc("t6_post", 4'b1111, 1'b1, 4'b0001);
    chk_out("t6_post", 1'b1, 2'd0, 72'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
